// File: rtl/axil_intr_pkg.sv
// Shared definitions for the AXI4-Lite interrupt controller:
// register offsets, response codes, FSM state types, strobe helper.
package axil_intr_pkg;

  localparam logic [4:0] ADDR_GIE = 5'h00;
  localparam logic [4:0] ADDR_IER = 5'h04;
  localparam logic [4:0] ADDR_ISR = 5'h08;
  localparam logic [4:0] ADDR_IAR = 5'h0C;
  localparam logic [4:0] ADDR_IPR = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/axil_intr_detect.sv
// Per-source interrupt detection producing the ISR set vector.
// Ports: i_clk, i_rst (sync, active-high), i_intr sources, o_set_vec.
module axil_intr_detect
  import axil_intr_pkg::*;
#(
  parameter int   NUM_INTR  = 1,
  parameter logic INTR_EDGE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_INTR-1:0] i_intr,
  output logic [NUM_INTR-1:0] o_set_vec
);

  logic [NUM_INTR-1:0] r_intr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_intr_d <= '0;
    else       r_intr_d <= i_intr;
  end

  // Edge mode fires once per rising edge; level mode keeps setting.
  assign o_set_vec = INTR_EDGE ? (i_intr & ~r_intr_d)
                               : i_intr;

endmodule

// File: rtl/axil_intr_ctrl.sv
// AXI4-Lite interrupt register file (GIE/IER/ISR/IAR/IPR) driving irq.
// Ports: ACLK/ARESET, S_AW*/S_W*/S_B*/S_AR*/S_R* lite slave, intr_in, irq.
// Option: INTR_SW_SET_EN makes a write to ISR OR data into ISR.
module axil_intr_ctrl
  import axil_intr_pkg::*;
#(
  parameter int   ADDR_W       = 5,
  parameter int   NUM_INTR     = 1,
  parameter logic INTR_EDGE    = 1'b1,
  parameter logic IRQ_ACT_HIGH = 1'b1
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AWADDR,
  input  logic [2:0]          S_AWPROT,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [31:0]         S_WDATA,
  input  logic [3:0]          S_WSTRB,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [ADDR_W-1:0]   S_ARADDR,
  input  logic [2:0]          S_ARPROT,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [31:0]         S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  input  logic [NUM_INTR-1:0] intr_in,
  output logic                irq
);

  localparam logic [31:0] INTR_MASK =
    (NUM_INTR >= 32) ? 32'hFFFF_FFFF
                     : ((32'd1 << NUM_INTR) - 32'd1);

  wr_state_t   r_wstate;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_aw_held;
  logic        r_w_held;
  logic [4:0]  r_aw_off;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  rd_state_t   r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        r_gie;
  logic [31:0] r_ier;
  logic [31:0] r_isr;
  logic        r_irq;

  logic [NUM_INTR-1:0] w_set_vec;
  logic [31:0] w_set32;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_have;
  logic        w_w_have;
  logic        w_wr_go;
  logic [4:0]  w_wr_off;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [31:0] w_wr_bits;
  logic        w_wr_ok;
  logic [31:0] w_ack;
  logic [31:0] w_sw_set;
  logic [4:0]  w_rd_off;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic        w_irq_act;
  logic        w_unused;

  axil_intr_detect #(
    .NUM_INTR  (NUM_INTR),
    .INTR_EDGE (INTR_EDGE)
  ) u_detect (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_intr    (intr_in),
    .o_set_vec (w_set_vec)
  );

  assign w_set32 = 32'(w_set_vec);

  // A beat counts as held either from an earlier capture or from
  // the handshake happening on this very edge.
  assign w_aw_hs   = S_AWVALID & r_awready;
  assign w_w_hs    = S_WVALID & r_wready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held | w_w_hs;
  assign w_wr_go   = (r_wstate == W_IDLE)
                   & w_aw_have & w_w_have;

  assign w_wr_off  = r_aw_held ? r_aw_off
                               : {S_AWADDR[4:2], 2'b00};
  assign w_wr_data = r_w_held ? r_wdata : S_WDATA;
  assign w_wr_strb = r_w_held ? r_wstrb : S_WSTRB;
  assign w_wr_bits = w_wr_data & strb_mask(w_wr_strb);
  assign w_wr_ok   = (w_wr_off <= ADDR_IPR);

  assign w_ack = (w_wr_go && w_wr_off == ADDR_IAR)
               ? (w_wr_bits & INTR_MASK) : '0;

`ifdef INTR_SW_SET_EN
  assign w_sw_set = (w_wr_go && w_wr_off == ADDR_ISR)
                  ? (w_wr_bits & INTR_MASK) : '0;
`else
  assign w_sw_set = '0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_off  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (w_wr_go) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? RESP_OKAY
                                 : RESP_SLVERR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
          end else begin
            if (w_aw_hs) begin
              r_aw_held <= 1'b1;
              r_aw_off  <= {S_AWADDR[4:2], 2'b00};
            end
            if (w_w_hs) begin
              r_w_held <= 1'b1;
              r_wdata  <= S_WDATA;
              r_wstrb  <= S_WSTRB;
            end
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_rd_off = {S_ARADDR[4:2], 2'b00};

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    unique case (w_rd_off)
      ADDR_GIE: w_rd_data = {31'b0, r_gie};
      ADDR_IER: w_rd_data = r_ier;
      ADDR_ISR: w_rd_data = r_isr;
      ADDR_IAR: w_rd_data = '0;
      ADDR_IPR: w_rd_data = r_isr & r_ier;
      default:  w_rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (S_ARVALID && r_arready) begin
            r_rstate  <= R_DATA;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_arready <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign w_irq_act = r_gie & |(r_isr & r_ier);

  // Sources set after the ack is applied, so a coincident set wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_gie <= 1'b0;
      r_ier <= '0;
      r_isr <= '0;
      r_irq <= ~IRQ_ACT_HIGH;
    end else begin
      if (w_wr_go && w_wr_off == ADDR_GIE
          && w_wr_strb[0])
        r_gie <= w_wr_data[0];
      if (w_wr_go && w_wr_off == ADDR_IER)
        r_ier <= ((r_ier & ~strb_mask(w_wr_strb))
                 | w_wr_bits) & INTR_MASK;
      r_isr <= ((r_isr & ~w_ack) | w_set32 | w_sw_set)
             & INTR_MASK;
      r_irq <= w_irq_act ? IRQ_ACT_HIGH : ~IRQ_ACT_HIGH;
    end
  end

  assign S_AWREADY = r_awready;
  assign S_WREADY  = r_wready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = r_arready;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;
  assign irq       = r_irq;

  assign w_unused = ^{S_AWPROT, S_ARPROT,
                      S_AWADDR, S_ARADDR};

endmodule

// File: tb/tb_axil_intr_ctrl.sv
// Bench for axil_intr_ctrl: edge/active-high and level/active-low
// instances on a shared bus, checked against a register-level model.
module tb_axil_intr_ctrl;

  localparam int N = 4;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0;
  logic        arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [N-1:0] intr = '0;

  logic        awready[2], wready[2], bvalid[2];
  logic        arready[2], rvalid[2], irq[2];
  logic [1:0]  bresp[2], rresp[2];
  logic [31:0] rdata[2];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 0;

  axil_intr_ctrl #(
    .ADDR_W(5), .NUM_INTR(N),
    .INTR_EDGE(1'b1), .IRQ_ACT_HIGH(1'b1)
  ) u_edge (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(awaddr), .S_AWPROT(3'b000),
    .S_AWVALID(awvalid), .S_AWREADY(awready[0]),
    .S_WDATA(wdata), .S_WSTRB(wstrb),
    .S_WVALID(wvalid), .S_WREADY(wready[0]),
    .S_BRESP(bresp[0]), .S_BVALID(bvalid[0]),
    .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARPROT(3'b000),
    .S_ARVALID(arvalid), .S_ARREADY(arready[0]),
    .S_RDATA(rdata[0]), .S_RRESP(rresp[0]),
    .S_RVALID(rvalid[0]), .S_RREADY(rready),
    .intr_in(intr), .irq(irq[0])
  );

  axil_intr_ctrl #(
    .ADDR_W(5), .NUM_INTR(N),
    .INTR_EDGE(1'b0), .IRQ_ACT_HIGH(1'b0)
  ) u_lvl (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(awaddr), .S_AWPROT(3'b000),
    .S_AWVALID(awvalid), .S_AWREADY(awready[1]),
    .S_WDATA(wdata), .S_WSTRB(wstrb),
    .S_WVALID(wvalid), .S_WREADY(wready[1]),
    .S_BRESP(bresp[1]), .S_BVALID(bvalid[1]),
    .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARPROT(3'b000),
    .S_ARVALID(arvalid), .S_ARREADY(arready[1]),
    .S_RDATA(rdata[1]), .S_RRESP(rresp[1]),
    .S_RVALID(rvalid[1]), .S_RREADY(rready),
    .intr_in(intr), .irq(irq[1])
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
  endtask

  // Register-level model, one copy per instance (0 edge, 1 level)
  logic          m_gie[2];
  logic [N-1:0]  m_ier[2], m_isr[2];
  logic          m_irq[2];
  logic          m_bv[2], m_rv[2];
  logic [1:0]    m_br[2], m_rr[2];
  logic [31:0]   m_rd[2];
  logic          m_awh[2], m_wh[2];
  logic [4:0]    m_awoff[2];
  logic [31:0]   m_wd[2];
  logic [3:0]    m_ws[2];
  logic [N-1:0]  m_prev;
  logic [N-1:0]  t_set, t_ack, t_sw;
  logic [31:0]   t_wv;
  logic          t_irq;

  task automatic model_read(input int k, input logic [4:0] a,
                            output logic [31:0] d,
                            output logic [1:0] r);
    d = '0;
    r = 2'b00;
    case (a & 5'h1C)
      5'h00: d = 32'(m_gie[k]);
      5'h04: d = 32'(m_ier[k]);
      5'h08: d = 32'(m_isr[k]);
      5'h0C: d = '0;
      5'h10: d = 32'(m_isr[k] & m_ier[k]);
      default: r = 2'b10;
    endcase
  endtask

  always @(posedge ACLK) begin
    for (int k = 0; k < 2; k++) begin
      if (ARESET) begin
        m_gie[k] = 0; m_ier[k] = '0; m_isr[k] = '0;
        m_irq[k] = 0; m_bv[k] = 0; m_rv[k] = 0;
        m_br[k] = 0; m_rr[k] = 0; m_rd[k] = '0;
        m_awh[k] = 0; m_wh[k] = 0;
      end else begin
        t_set = (k == 0) ? (intr & ~m_prev) : intr;
        t_ack = '0;
        t_sw  = '0;
        t_irq = m_gie[k] && ((m_isr[k] & m_ier[k]) != '0);
        if (m_rv[k]) begin
          if (rready) m_rv[k] = 0;
        end else if (arvalid && arready[k]) begin
          m_rv[k] = 1;
          model_read(k, araddr, m_rd[k], m_rr[k]);
        end
        if (m_bv[k]) begin
          if (bready) m_bv[k] = 0;
        end else begin
          if (awvalid && awready[k]) begin
            m_awh[k] = 1;
            m_awoff[k] = awaddr & 5'h1C;
          end
          if (wvalid && wready[k]) begin
            m_wh[k] = 1;
            m_wd[k] = wdata;
            m_ws[k] = wstrb;
          end
          if (m_awh[k] && m_wh[k]) begin
            m_awh[k] = 0;
            m_wh[k] = 0;
            m_bv[k] = 1;
            m_br[k] = 2'b00;
            t_wv = m_wd[k];
            for (int b = 0; b < 4; b++)
              if (!m_ws[k][b]) t_wv[b*8 +: 8] = 8'h00;
            case (m_awoff[k])
              5'h00: if (m_ws[k][0]) m_gie[k] = m_wd[k][0];
              5'h04: begin
                for (int i = 0; i < N; i++)
                  if (m_ws[k][i/8]) m_ier[k][i] = t_wv[i];
              end
              5'h08: begin
`ifdef INTR_SW_SET_EN
                t_sw = t_wv[N-1:0];
`endif
              end
              5'h0C: t_ack = t_wv[N-1:0];
              5'h10: ;
              default: m_br[k] = 2'b10;
            endcase
          end
        end
        m_isr[k] = (m_isr[k] & ~t_ack) | t_set | t_sw;
        m_irq[k] = t_irq;
      end
    end
    m_prev = ARESET ? '0 : intr;
  end

  always @(negedge ACLK) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("irq[%0d]", k), 32'(irq[k]),
              32'((k == 0) ? m_irq[k] : !m_irq[k]));
        check($sformatf("bvalid[%0d]", k),
              32'(bvalid[k]), 32'(m_bv[k]));
        check($sformatf("rvalid[%0d]", k),
              32'(rvalid[k]), 32'(m_rv[k]));
        if (m_bv[k])
          check($sformatf("bresp[%0d]", k),
                32'(bresp[k]), 32'(m_br[k]));
        if (m_rv[k]) begin
          check($sformatf("rdata[%0d]", k),
                rdata[k], m_rd[k]);
          check($sformatf("rresp[%0d]", k),
                32'(rresp[k]), 32'(m_rr[k]));
        end
      end
    end
  end

  task automatic axi_write(input logic [4:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_ok = 0;
    bit w_ok = 0;
    int n = 0;
    @(negedge ACLK);
    awaddr = a; awvalid = 1;
    wdata = d; wstrb = s; wvalid = 1;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(posedge ACLK);
      if (awvalid && awready[0]) aw_ok = 1;
      if (wvalid && wready[0]) w_ok = 1;
      @(negedge ACLK);
      if (aw_ok) awvalid = 0;
      if (w_ok) wvalid = 0;
      n++;
    end
    n = 0;
    while (!bvalid[0] && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!bvalid[0]) begin
      check("write_timeout", 0, 1);
      awvalid = 0; wvalid = 0;
      resp = 2'b11;
    end else begin
      resp = bresp[0];
      bready = 1;
      @(negedge ACLK);
      bready = 0;
    end
  endtask

  task automatic axi_read(input logic [4:0] a,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    bit ok = 0;
    int n = 0;
    @(negedge ACLK);
    araddr = a; arvalid = 1;
    while (!ok && n < 20) begin
      @(posedge ACLK);
      if (arready[0]) ok = 1;
      @(negedge ACLK);
      if (ok) arvalid = 0;
      n++;
    end
    arvalid = 0;
    if (!rvalid[0]) begin
      check("read_timeout", 0, 1);
      d = 'x; resp = 2'b11;
    end else begin
      d = rdata[0];
      resp = rresp[0];
      rready = 1;
      @(negedge ACLK);
      rready = 0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int cnt;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    cmp_en = 1;
    check("rst_awready", 32'(awready[0]), 0);
    check("rst_wready",  32'(wready[0]), 0);
    check("rst_arready", 32'(arready[0]), 0);
    check("rst_bvalid",  32'(bvalid[0]), 0);
    check("rst_rvalid",  32'(rvalid[0]), 0);
    check("rst_rdata",   rdata[0], 0);
    check("rst_irq_hi",  32'(irq[0]), 0);
    check("rst_irq_lo",  32'(irq[1]), 1);
    ARESET = 0;

    axi_write(5'h00, 32'h1, 4'hF, r);
    check("gie_bresp", 32'(r), 0);
    axi_write(5'h04, 32'h1, 4'hF, r);
    check("ier_bresp", 32'(r), 0);
    @(negedge ACLK); intr = 4'b0001;
    @(negedge ACLK); intr = 4'b0000;
    @(negedge ACLK);
    check("pulse_irq_hi", 32'(irq[0]), 1);
    check("pulse_irq_lo", 32'(irq[1]), 0);
    axi_read(5'h10, d, r);
    check("ipr_after_pulse", d, 32'h1);
    axi_read(5'h08, d, r);
    check("isr_after_pulse", d, 32'h1);

    axi_write(5'h0C, 32'h1, 4'hF, r);
    check("iar_bresp", 32'(r), 0);
    check("ack_irq_hi", 32'(irq[0]), 0);
    check("ack_irq_lo", 32'(irq[1]), 1);
    axi_read(5'h10, d, r);
    check("ipr_after_ack", d, 32'h0);
    axi_read(5'h0C, d, r);
    check("iar_reads0", d, 32'h0);

    intr = 4'b0001;
    axi_write(5'h0C, 32'h1, 4'hF, r);
    axi_read(5'h08, d, r);
    check("edge_isr_acked", d, 32'h0);
    check("held_irq_hi", 32'(irq[0]), 0);
    check("held_irq_lo", 32'(irq[1]), 0);
    intr = 4'b0000;
    axi_write(5'h0C, 32'h1, 4'hF, r);
    check("lvl_release_irq", 32'(irq[1]), 1);

    @(negedge ACLK);
    awaddr = 5'h04; awvalid = 1;
    @(posedge ACLK);
    @(negedge ACLK); awvalid = 0;
    axi_read(5'h04, d, r);
    check("ier_before_w", d, 32'h1);
    check("no_b_before_w", 32'(bvalid[0]), 0);
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
    @(posedge ACLK);
    @(negedge ACLK); wvalid = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bvalid[0]) cnt++;
      @(negedge ACLK);
    end
    check("bvalid_held", 32'(cnt), 4);
    bready = 1;
    @(negedge ACLK); bready = 0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid[0]) cnt++;
      @(negedge ACLK);
    end
    check("single_b_beat", 32'(cnt), 0);
    axi_read(5'h04, d, r);
    check("ier_after_w", d, 32'h5);

    axi_write(5'h04, 32'hFFFF_FF0A, 4'b0010, r);
    axi_read(5'h04, d, r);
    check("strb_lane_kept", d, 32'h5);
    axi_write(5'h04, 32'hFFFF_FF03, 4'b0001, r);
    axi_read(5'h04, d, r);
    check("strb_lane0", d, 32'h3);

    axi_read(5'h14, d, r);
    check("bad_rd_resp", 32'(r), 2);
    check("bad_rd_data", d, 0);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, r);
    check("bad_wr_resp", 32'(r), 2);
    axi_read(5'h00, d, r);
    check("gie_unchanged", d, 32'h1);
    axi_read(5'h04, d, r);
    check("ier_unchanged", d, 32'h3);

    axi_write(5'h08, 32'h2, 4'hF, r);
    check("isr_wr_bresp", 32'(r), 0);
    axi_read(5'h08, d, r);
`ifdef INTR_SW_SET_EN
    check("sw_set_isr", d, 32'h2);
    check("sw_set_irq", 32'(irq[0]), 1);
`else
    check("ro_isr", d, 32'h0);
    check("ro_isr_irq", 32'(irq[0]), 0);
`endif
    axi_write(5'h0C, 32'hF, 4'hF, r);

    @(negedge ACLK); intr = 4'b0100;
    @(negedge ACLK); intr = 4'b0000;
    @(negedge ACLK);
    check("masked_irq", 32'(irq[0]), 0);
    axi_write(5'h04, 32'h4, 4'hF, r);
    check("reenable_irq", 32'(irq[0]), 1);
    axi_write(5'h04, 32'h0, 4'hF, r);
    check("disable_irq", 32'(irq[0]), 0);
    axi_read(5'h08, d, r);
    check("isr_retained", d, 32'h4);
    axi_write(5'h04, 32'h4, 4'hF, r);
    axi_write(5'h00, 32'h0, 4'hF, r);
    check("gie_off_irq", 32'(irq[0]), 0);

    @(negedge ACLK);
    awaddr = 5'h04; awvalid = 1;
    @(negedge ACLK);
    ARESET = 1; awvalid = 0;
    @(negedge ACLK);
    ARESET = 0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid[0]) cnt++;
      @(negedge ACLK);
    end
    check("abort_no_b", 32'(cnt), 0);
    axi_read(5'h04, d, r);
    check("abort_ier", d, 32'h0);
    axi_read(5'h08, d, r);
    check("abort_isr", d, 32'h0);

    repeat (2) @(negedge ACLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
